// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param
// Purpose  : Parametrised single-clock FIFO with extended-pointer full/empty
//            detection, occupancy count, almost-full/almost-empty thresholds,
//            sticky overflow/underflow flags and a synchronous flush.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1           rising-edge clock
//   rst_n        in   1           asynchronous active-low reset
//   flush        in   1           synchronous clear, highest priority
//   wr_en        in   1           write request
//   data_in      in   DATA_WIDTH  write data
//   rd_en        in   1           read request
//   data_out     out  DATA_WIDTH  registered read data
//   rd_valid     out  1           data_out was updated by the previous edge
//   full         out  1           count == DEPTH
//   empty        out  1           count == 0
//   almost_full  out  1           count >= AF_LEVEL
//   almost_empty out  1           count <= AE_LEVEL
//   count        out  AW+1        current occupancy 0..DEPTH
//   overflow     out  1           sticky: write attempted while full
//   underflow    out  1           sticky: read attempted while empty
// ============================================================================
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [AW:0]           count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [AW:0] c_AF_LEVEL = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] c_AE_LEVEL = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0] c_PTR_ONE  = (AW+1)'(1);

  // Pointers carry one extra bit so that full and empty are distinguishable
  // when the address bits coincide.
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_rd_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic [AW:0]           w_count;
  logic                  w_wr_acc;
  logic                  w_rd_acc;

  // Status is decoded only from registered pointers, so no path exists from
  // wr_en/rd_en to any status output.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // Modulo-2*DEPTH subtraction yields the occupancy directly.
  assign w_count = r_wr_ptr - r_rd_ptr;

  // A flush cycle ignores both requests.
  assign w_wr_acc = wr_en && !w_full  && !flush;
  assign w_rd_acc = rd_en && !w_empty && !flush;

  // Storage has no reset; its contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_data_out  <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      // data_out deliberately holds across a flush.
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_rd_acc) begin
        r_data_out <= r_mem[r_rd_ptr[AW-1:0]];
        r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
      end
      r_rd_valid <= w_rd_acc;
      if (wr_en && w_full) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign data_out     = r_data_out;
  assign rd_valid     = r_rd_valid;
  assign full         = w_full;
  assign empty        = w_empty;
  assign count        = w_count;
  assign almost_full  = (w_count >= c_AF_LEVEL);
  assign almost_empty = (w_count <= c_AE_LEVEL);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_param
// Purpose  : Directed self-checking bench for sync_fifo_param configured as
//            8 bits x 4 entries, AF_LEVEL=3, AE_LEVEL=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

  localparam int DW = 8;
  localparam int DP = 4;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          wr_en;
  logic [DW-1:0] data_in;
  logic          rd_en;
  logic [DW-1:0] data_out;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [2:0]    count;
  logic          overflow;
  logic          underflow;

  int n_checks = 0;
  int n_fail   = 0;

  sync_fifo_param #(
    .DATA_WIDTH (DW),
    .DEPTH      (DP),
    .AF_LEVEL   (3),
    .AE_LEVEL   (1)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of requests, let the edge happen, sample 1 ns later.
  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    flush   = f;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    cyc(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic rd();
    cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  logic [DW-1:0] fill_vals [4];
  logic [DW-1:0] nxt_out;
  logic [DW-1:0] nxt_in;

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;
    fill_vals[0] = 8'hA1;
    fill_vals[1] = 8'hB2;
    fill_vals[2] = 8'hC3;
    fill_vals[3] = 8'hD4;

    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_empty", empty, 1);
    check("rst_ae", almost_empty, 1);
    check("rst_full", full, 0);
    check("rst_af", almost_full, 0);
    check("rst_count", count, 0);
    check("rst_dout", data_out, 8'h00);
    check("rst_rdv", rd_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_udf", underflow, 0);

    // ---------------- fill ----------------
    wr(8'hA1);
    check("fill1_count", count, 1);
    check("fill1_ae", almost_empty, 1);
    check("fill1_empty", empty, 0);
    wr(8'hB2);
    check("fill2_count", count, 2);
    check("fill2_ae", almost_empty, 0);
    check("fill2_af", almost_full, 0);
    wr(8'hC3);
    check("fill3_count", count, 3);
    check("fill3_af", almost_full, 1);
    check("fill3_full", full, 0);
    wr(8'hD4);
    check("fill4_count", count, 4);
    check("fill4_full", full, 1);

    // ---------------- overflow ----------------
    wr(8'hEE);
    check("ovf_count", count, 4);
    check("ovf_flag", overflow, 1);
    check("ovf_full", full, 1);

    // ---------------- drain ----------------
    for (int i = 0; i < 4; i++) begin
      rd();
      check("drain_data", data_out, fill_vals[i]);
      check("drain_rdv", rd_valid, 1);
      check("drain_count", count, 3 - i);
    end
    check("drain_empty", empty, 1);
    check("ovf_sticky", overflow, 1);
    cyc(1'b0, '0, 1'b0, 1'b0);
    check("idle_rdv", rd_valid, 0);
    check("idle_dout_hold", data_out, 8'hD4);

    // ---------------- underflow ----------------
    rd();
    check("udf_flag", underflow, 1);
    check("udf_rdv", rd_valid, 0);
    check("udf_dout", data_out, 8'hD4);
    check("udf_count", count, 0);

    // ---------------- simultaneous at count=2 ----------------
    wr(8'h01);
    wr(8'h02);
    check("sim_pre_count", count, 2);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, DW'(i + 3), 1'b1, 1'b0);
      check("sim_count", count, 2);
      check("sim_data", data_out, DW'(i + 1));
      check("sim_rdv", rd_valid, 1);
    end

    // ---------------- flush clears flags ----------------
    cyc(1'b0, '0, 1'b0, 1'b1);
    check("fl1_count", count, 0);
    check("fl1_empty", empty, 1);
    check("fl1_ovf", overflow, 0);
    check("fl1_udf", underflow, 0);
    check("fl1_dout_hold", data_out, 8'h06);

    // ---------------- simultaneous while full ----------------
    wr(8'h11);
    wr(8'h22);
    wr(8'h33);
    wr(8'h44);
    check("fullsim_pre", full, 1);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    check("fullsim_count", count, 3);
    check("fullsim_ovf", overflow, 1);
    check("fullsim_data", data_out, 8'h11);
    rd();
    check("fullsim_d2", data_out, 8'h22);
    rd();
    check("fullsim_d3", data_out, 8'h33);
    rd();
    check("fullsim_d4", data_out, 8'h44);
    check("fullsim_empty", empty, 1);

    // ---------------- simultaneous while empty ----------------
    cyc(1'b1, 8'h66, 1'b1, 1'b0);
    check("emptysim_count", count, 1);
    check("emptysim_udf", underflow, 1);
    check("emptysim_rdv", rd_valid, 0);
    rd();
    check("emptysim_data", data_out, 8'h66);
    check("emptysim_empty", empty, 1);

    // ---------------- wrap-around: 20 words, occupancy 0..4 ----------------
    nxt_in  = 8'h80;
    nxt_out = 8'h80;
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) begin
        wr(nxt_in);
        nxt_in = nxt_in + 8'h01;
      end
      check("wrap_full", full, 1);
      check("wrap_cnt4", count, 4);
      for (int k = 0; k < 4; k++) begin
        rd();
        check("wrap_data", data_out, nxt_out);
        nxt_out = nxt_out + 8'h01;
      end
      check("wrap_empty", empty, 1);
      check("wrap_nfull", full, 0);
    end

    // ---------------- flush with wr_en at count=3, overflow=1 ----------------
    wr(8'hC0);
    wr(8'hC1);
    wr(8'hC2);
    wr(8'hC3);
    wr(8'hCE);
    rd();
    check("fl2_pre_count", count, 3);
    check("fl2_pre_ovf", overflow, 1);
    check("fl2_pre_data", data_out, 8'hC0);
    cyc(1'b1, 8'h77, 1'b0, 1'b1);
    check("fl2_count", count, 0);
    check("fl2_empty", empty, 1);
    check("fl2_ovf", overflow, 0);
    check("fl2_udf", underflow, 0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    check("fl2_nowrite", count, 0);

    // ---------------- asynchronous reset mid-burst ----------------
    wr(8'h5A);
    wr(8'h6B);
    wr_en   = 1'b1;
    data_in = 8'h7C;
    rd_en   = 1'b1;
    @(posedge clk);
    #1;
    check("ar_pre_data", data_out, 8'h5A);
    check("ar_pre_rdv", rd_valid, 1);
    check("ar_pre_count", count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_dout", data_out, 8'h00);
    check("ar_rdv", rd_valid, 0);
    check("ar_count", count, 0);
    check("ar_empty", empty, 1);
    check("ar_ae", almost_empty, 1);
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ar_post_count", count, 0);
    wr(8'h9D);
    check("ar_resume_count", count, 1);
    rd();
    check("ar_resume_data", data_out, 8'h9D);
    check("ar_resume_rdv", rd_valid, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
